duty_button_conditioner: RTL and testbench

//   Upstream front end for pwm_generator. Conditions two raw push-buttons (up/down) into

---
 rtl/duty_button_conditioner.sv | 157 +++++++++++++++
 tb/tb_duty_button_conditioner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_button_conditioner.sv
// Push-button front end for pwm_generator: per-button 2-FF synchroniser, debounce,
// press / hold-to-repeat FSM and up/down lockout, producing one-cycle duty requests.
module duty_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic increase_duty,
   output logic decrease_duty,
   output logic btn_up_level,
   output logic btn_down_level
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
   localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam bit               RPT_EN   = (REPEAT_DELAY != 0);

   logic [1:0] w_raw;
   logic [1:0] w_lvl;
   logic [1:0] w_pulse;

   assign w_raw = {btn_down_raw, btn_up_raw};

   // Index 0 is the up button, index 1 the down button.
   for (genvar g = 0; g < 2; g++) begin : g_btn
      logic             r_ff1;
      logic             r_ff2;
      logic             r_lvl;
      logic             r_pulse;
      logic [CNT_W-1:0] r_db_cnt;
      logic [CNT_W-1:0] r_rpt_cnt;
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] w_rpt_nxt;
      logic             w_pulse_nxt;
      logic             w_other;

      assign w_other    = (g == 0) ? w_lvl[1] : w_lvl[0];
      assign w_lvl[g]   = r_lvl;
      assign w_pulse[g] = r_pulse;

      // Two-flop synchroniser for the asynchronous raw button.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
         end else begin
            r_ff1 <= w_raw[g];
            r_ff2 <= r_ff1;
         end
      end

      // Debounce: accept a new level only after it persisted DEBOUNCE_CYCLES cycles.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_lvl    <= 1'b0;
            r_db_cnt <= CNT_ZERO;
         end else if (r_ff2 == r_lvl) begin
            r_db_cnt <= CNT_ZERO;
         end else if (r_db_cnt == DB_LAST) begin
            r_lvl    <= r_ff2;
            r_db_cnt <= CNT_ZERO;
         end else begin
            r_db_cnt <= r_db_cnt + CNT_ONE;
         end
      end

      // Press / auto-repeat / lockout next-state and pulse decode.
      always_comb begin
         w_state_nxt = r_state;
         w_rpt_nxt   = r_rpt_cnt;
         w_pulse_nxt = 1'b0;
         if (!r_lvl) begin
            w_state_nxt = ST_IDLE;
            w_rpt_nxt   = CNT_ZERO;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_other) begin
                     w_state_nxt = ST_LOCK;
                  end else begin
                     w_pulse_nxt = 1'b1;
                     w_rpt_nxt   = CNT_ZERO;
                     w_state_nxt = ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (w_other) begin
                     w_state_nxt = ST_LOCK;
                     w_rpt_nxt   = CNT_ZERO;
                  end else if (RPT_EN && (r_rpt_cnt == RD_LAST)) begin
                     w_pulse_nxt = 1'b1;
                     w_rpt_nxt   = CNT_ZERO;
                     w_state_nxt = ST_REPEAT;
                  end else if (RPT_EN) begin
                     w_rpt_nxt = r_rpt_cnt + CNT_ONE;
                  end else begin
                     w_rpt_nxt = r_rpt_cnt;
                  end
               end
               ST_REPEAT: begin
                  if (w_other) begin
                     w_state_nxt = ST_LOCK;
                     w_rpt_nxt   = CNT_ZERO;
                  end else if (r_rpt_cnt == RR_LAST) begin
                     w_pulse_nxt = 1'b1;
                     w_rpt_nxt   = CNT_ZERO;
                  end else begin
                     w_rpt_nxt = r_rpt_cnt + CNT_ONE;
                  end
               end
               ST_LOCK: begin
                  w_state_nxt = ST_LOCK;
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_rpt_nxt   = CNT_ZERO;
               end
            endcase
         end
      end

      // FSM state, repeat counter and registered request pulse.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= CNT_ZERO;
            r_pulse   <= 1'b0;
         end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_nxt;
            r_pulse   <= w_pulse_nxt;
         end
      end
   end

   assign increase_duty  = w_pulse[0];
   assign decrease_duty  = w_pulse[1];
   assign btn_up_level   = w_lvl[0];
   assign btn_down_level = w_lvl[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Randomised and directed bench for duty_button_conditioner against a timing-arithmetic
// reference model (raw history windows for debounce, elapsed-time rules for repeats).
module tb_duty_button_conditioner;

   localparam int D    = 4;
   localparam int RD   = 20;
   localparam int RR   = 8;
   localparam int MAXN = 8192;

   logic clk;
   logic reset;
   logic btn_up_raw;
   logic btn_down_raw;
   logic increase_duty;
   logic decrease_duty;
   logic btn_up_level;
   logic btn_down_level;

   int n_pass;
   int n_checks;
   int n;
   int base;
   int t0;
   bit up_h [MAXN];
   bit dn_h [MAXN];
   bit m_lvl    [2];
   bit m_active [2];
   bit m_locked [2];
   bit m_pulse  [2];
   int m_press  [2];
   int inc_t[$];
   int dec_t[$];
   int exp_t3 [6] = '{7, 27, 35, 43, 51, 59};

   duty_button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_RATE    (RR),
      .CNT_W          (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_up_raw    (btn_up_raw),
      .btn_down_raw  (btn_down_raw),
      .increase_duty (increase_duty),
      .decrease_duty (decrease_duty),
      .btn_up_level  (btn_up_level),
      .btn_down_level(btn_down_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, n);
   endtask

   // Raw level sampled by the first sync flop at edge idx; nothing before reset release counts.
   function automatic bit raw_at(input int b, input int idx);
      if (idx < base) return 1'b0;
      return (b == 0) ? up_h[idx] : dn_h[idx];
   endfunction

   // True when the synchronised value seen by the last D edges before edge e all equal v.
   function automatic bit window_all(input int b, input int e, input bit v);
      for (int j = 0; j < D; j++)
         if (raw_at(b, e - 2 - j) != v) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input bit u, input bit d);
      bit pl [2];
      int el;
      int o;
      if (n < MAXN) begin
         up_h[n] = u;
         dn_h[n] = d;
      end
      pl = m_lvl;
      for (int b = 0; b < 2; b++)
         if (window_all(b, n, !pl[b])) m_lvl[b] = !pl[b];
      for (int b = 0; b < 2; b++) begin
         o = 1 - b;
         m_pulse[b] = 1'b0;
         if (!pl[b]) begin
            m_active[b] = 1'b0;
         end else if (!m_active[b]) begin
            m_active[b] = 1'b1;
            m_press[b]  = n;
            m_locked[b] = pl[o];
            m_pulse[b]  = !pl[o];
         end else if (m_locked[b]) begin
            m_pulse[b] = 1'b0;
         end else if (pl[o]) begin
            m_locked[b] = 1'b1;
         end else begin
            el = n - m_press[b];
            m_pulse[b] = (RD != 0) && ((el == RD) || ((el > RD) && ((el - RD) % RR == 0)));
         end
      end
      n++;
   endtask

   task automatic step(input bit u, input bit d);
      btn_up_raw   = u;
      btn_down_raw = d;
      @(posedge clk);
      model_edge(u, d);
      @(negedge clk);
      check("up_level", btn_up_level, m_lvl[0]);
      check("down_level", btn_down_level, m_lvl[1]);
      check("increase", increase_duty, m_pulse[0]);
      check("decrease", decrease_duty, m_pulse[1]);
      check("exclusive", increase_duty & decrease_duty, 0);
      if (increase_duty) inc_t.push_back(n - t0);
      if (decrease_duty) dec_t.push_back(n - t0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_inc"}, increase_duty, 0);
      check({tag, "_dec"}, decrease_duty, 0);
      check({tag, "_uplvl"}, btn_up_level, 0);
      check({tag, "_dnlvl"}, btn_down_level, 0);
   endtask

   task automatic apply_reset(input int cycles);
      reset = 1'b0;
      #1;
      check_all_zero("rst_async");
      for (int b = 0; b < 2; b++) begin
         m_lvl[b]    = 1'b0;
         m_active[b] = 1'b0;
         m_locked[b] = 1'b0;
         m_pulse[b]  = 1'b0;
      end
      repeat (cycles) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         check_all_zero("rst_hold");
      end
      reset = 1'b1;
      base  = n;
   endtask

   task automatic mark();
      t0 = n;
      inc_t.delete();
      dec_t.delete();
   endtask

   initial begin
      int hold_u;
      int hold_d;
      bit cu;
      bit cd;
      n_pass = 0;
      n_checks = 0;
      n = 0;
      base = 0;
      t0 = 0;
      btn_up_raw = 1'b0;
      btn_down_raw = 1'b0;
      apply_reset(3);
      repeat (5) step(1'b0, 1'b0);

      // Single press and release.
      mark();
      repeat (10) step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);
      check("t1_inc_count", inc_t.size(), 1);
      check("t1_inc_time", (inc_t.size() > 0) ? inc_t[0] : -1, 7);
      check("t1_dec_count", dec_t.size(), 0);

      // Contact bounce every 2 cycles, then settled press.
      mark();
      for (int i = 0; i < 12; i++) step(((i / 2) % 2) == 0, 1'b0);
      repeat (15) step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);
      check("t2_inc_count", inc_t.size(), 1);
      check("t2_inc_time", (inc_t.size() > 0) ? inc_t[0] : -1, 19);

      // Long hold with auto-repeat.
      mark();
      for (int i = 0; i < 75; i++) begin
         step(1'b0, i < 55);
         if (n - t0 == 60) check("t3_level_high", btn_down_level, 1);
         if (n - t0 == 61) check("t3_level_low", btn_down_level, 0);
      end
      check("t3_dec_count", dec_t.size(), 6);
      for (int i = 0; i < 6; i++)
         check("t3_dec_time", (i < dec_t.size()) ? dec_t[i] : -1, exp_t3[i]);
      check("t3_inc_count", inc_t.size(), 0);

      // Simultaneous press locks both; fresh up press needed.
      mark();
      for (int i = 0; i < 110; i++) step((i < 60) || ((i >= 80) && (i < 95)), i < 30);
      check("t4_inc_count", inc_t.size(), 1);
      check("t4_inc_time", (inc_t.size() > 0) ? inc_t[0] : -1, 87);
      check("t4_dec_count", dec_t.size(), 0);

      // Reset in the middle of a hold, button kept pressed through release.
      mark();
      repeat (30) step(1'b1, 1'b0);
      apply_reset(2);
      mark();
      repeat (20) step(1'b1, 1'b0);
      check("t5_inc_count", inc_t.size(), 1);
      check("t5_inc_time", (inc_t.size() > 0) ? inc_t[0] : -1, 7);
      repeat (20) step(1'b0, 1'b0);

      // Short glitch on down.
      mark();
      repeat (3) step(1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b0);
      check("t6_dec_count", dec_t.size(), 0);
      check("t6_inc_count", inc_t.size(), 0);
      check("t6_level", btn_down_level, 0);

      // Random bursts of glitches and holds on both buttons, occasional reset.
      hold_u = 0;
      hold_d = 0;
      cu = 1'b0;
      cd = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_u == 0) begin
            cu = ~cu;
            hold_u = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 70));
         end
         if (hold_d == 0) begin
            cd = ~cd;
            hold_d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 70));
         end
         hold_u--;
         hold_d--;
         if ($urandom_range(0, 999) == 0) apply_reset(int'($urandom_range(1, 3)));
         step(cu, cd);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
